prog_encoder: RTL
=================

# prog_encoder

Program-stream encoder: accepts symbolic instructions (kind, ALU operation, register indices, immediate) over a valid/ready handshake. Packs each into a 32-bit RV32I word using exactly the opcode/funct3/funct7/immediate layouts the control decoder consumes. Writes the words sequentially into instruction memory through a write port. It is the producer end of the instruction-decode path, used by bring-up and self-test to load programs without an external assembler.

## Interface
- AW, 6: instruction-memory word-address width; capacity 2**AW words.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse; begins a load at word 0.
- in_valid  in  1  instruction beat valid.
- in_ready  out  1  encoder accepts beat this cycle.
- in_kind  in  3  0 R-type, 1 I-ALU, 2 LW, 3 SW, 4 BEQ, 5 JAL; 6–7 illegal.
- in_alu  in  3  ALUControl code: 000 add, 001 sub, 010 and, 011 or, 101 slt; others illegal (R/I-ALU only).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  21  signed immediate, byte offset for SW/BEQ/JAL.
- in_last  in  1  final instruction of program.
- imem_we  out  1  write strobe.
- imem_addr  out  AW  word address.
- imem_wdata  out  32  encoded instruction.
- err  out  1  one-cycle pulse: beat rejected.
- busy  out  1  state is LOAD.
- done  out  1  state is DONE.
- count  out  AW+1  words written this load.

## Operation
- FSM IDLE → LOAD on start; LOAD → DONE after accepting in_last or the beat filling word 2**AW−1; DONE → LOAD on start; start in LOAD ignored.
- Entering LOAD clears count and the address pointer to 0.
- in_ready = (state==LOAD); memory always accepts, so no back-pressure beyond state.
- Encoding, unused fields zero:
  - R: op 0110011; funct3 add/sub 000, slt 010, or 110, and 111; funct7 0100000 for sub, else 0.
  - I-ALU: op 0010011, same funct3, imm[11:0] in [31:20].
  - LW: op 0000011, funct3 010.
  - SW: op 0100011, funct3 010, imm[11:5]→[31:25], imm[4:0]→[11:7].
  - BEQ: op 1100011, funct3 000, {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - JAL: op 1101111, {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Legality, any violation → err, no write, address/count unchanged:
  - kind 6–7.
  - Illegal in_alu for R.
  - sub or illegal in_alu for I-ALU.
  - I/LW/SW imm outside −2048..2047.
  - BEQ outside −4096..4094 or odd.
  - JAL outside −1048576..1048574 or odd.
- in_last on a rejected beat still ends the load (→ DONE).
- Each accepted legal beat increments address and count by 1 (AW+1-bit count, reaches 2**AW at full, never wraps).

## Timing
- Latency 1: beat accepted at edge N → imem_we/addr/wdata/err valid during cycle N+1, one cycle only.
- Back-to-back beats: one write per cycle.
- State → DONE at the same edge that registers the final write; done rises in cycle N+1 alongside the last imem_we.
- Reset (any state, mid-load included) at next edge:
  - state IDLE.
  - in_ready, imem_we, err, busy, done = 0.
  - imem_addr, imem_wdata, count = 0.
  - The pending write is dropped.
- start and an accepted beat cannot coincide (in_ready is 0 outside LOAD).

## Structure
- Shared package riscv_pkg: kind codes, ALUControl codes, opcode constants, funct3/funct7 values. The same constants serve the main and ALU decoders.
- One combinational sub-module, instr_pack: fields in → {word, illegal} out.
- FSM, counters and output register in prog_encoder.

## Test plan
- start; add x3,x1,x2; sub x5,x6,x7 with in_last → writes 0x002081B3 @0, 0x407302B3 @1; done=1, count=2.
- lw x6,-4(x9); sw x6,8(x9) → 0xFFC4A303 @0, 0x0064A423 @1.
- beq x1,x2,8; jal x1,8 → 0x00208463, 0x008000EF at consecutive addresses, back-to-back cycles.
- addi imm 2048, beq imm 3, I-ALU sub, kind 7 → four err pulses, no imem_we, count unchanged; the next legal beat writes @ previous address.
- AW=2: five beats without in_last → four writes @0..3, DONE after the fourth; in_ready=0 and the fifth beat is ignored.
- reset_n low for one cycle mid-load, coinciding with an accepted beat → no write the next cycle, all outputs 0, IDLE; a fresh start writes from @0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the program encoder and the control/ALU decoders:
// symbolic instruction kinds, ALUControl codes, opcodes and funct fields.
package riscv_pkg;

    localparam logic [2:0] KIND_R    = 3'd0;
    localparam logic [2:0] KIND_IALU = 3'd1;
    localparam logic [2:0] KIND_LW   = 3'd2;
    localparam logic [2:0] KIND_SW   = 3'd3;
    localparam logic [2:0] KIND_BEQ  = 3'd4;
    localparam logic [2:0] KIND_JAL  = 3'd5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: one symbolic instruction in, its RV32I word and an
// illegal flag out. Unused fields of each format stay zero.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  i_kind,
    input  logic [2:0]  i_alu,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [20:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    logic [2:0] w_f3;
    logic       w_alu_ok;
    logic       w_fit12;
    logic       w_fit13;
    logic       w_even;

    // Signed range tests: all bits above the field's sign bit must match it.
    assign w_fit12 = (&i_imm[20:11]) | ~(|i_imm[20:11]);
    assign w_fit13 = (&i_imm[20:12]) | ~(|i_imm[20:12]);
    assign w_even  = ~i_imm[0];

    // ALUControl code to funct3, flagging codes with no encoding.
    always_comb begin
        w_f3     = F3_ADD_SUB;
        w_alu_ok = 1'b1;
        case (i_alu)
            ALU_ADD: w_f3 = F3_ADD_SUB;
            ALU_SUB: w_f3 = F3_ADD_SUB;
            ALU_AND: w_f3 = F3_AND;
            ALU_OR:  w_f3 = F3_OR;
            ALU_SLT: w_f3 = F3_SLT;
            default: w_alu_ok = 1'b0;
        endcase
    end

    // Field packing and legality per instruction kind.
    always_comb begin
        o_word    = 32'd0;
        o_illegal = 1'b0;
        case (i_kind)
            KIND_R: begin
                o_word    = {(i_alu == ALU_SUB) ? F7_SUB : F7_ZERO,
                             i_rs2, i_rs1, w_f3, i_rd, OP_R};
                o_illegal = ~w_alu_ok;
            end
            KIND_IALU: begin
                o_word    = {i_imm[11:0], i_rs1, w_f3, i_rd, OP_IALU};
                o_illegal = ~w_alu_ok | (i_alu == ALU_SUB) | ~w_fit12;
            end
            KIND_LW: begin
                o_word    = {i_imm[11:0], i_rs1, F3_WORD, i_rd, OP_LW};
                o_illegal = ~w_fit12;
            end
            KIND_SW: begin
                o_word    = {i_imm[11:5], i_rs2, i_rs1, F3_WORD, i_imm[4:0], OP_SW};
                o_illegal = ~w_fit12;
            end
            KIND_BEQ: begin
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                             i_imm[4:1], i_imm[11], OP_BEQ};
                o_illegal = ~w_fit13 | ~w_even;
            end
            KIND_JAL: begin
                // 21-bit input already spans the full JAL range; only alignment can fail.
                o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
                o_illegal = ~w_even;
            end
            default: begin
                o_word    = 32'd0;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/prog_encoder.sv
// Program-stream encoder: accepts symbolic instruction beats while loading and
// writes their RV32I encodings to consecutive instruction-memory words.
module prog_encoder
    import riscv_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_kind,
    input  logic [2:0]    in_alu,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [20:0]   in_imm,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          err,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'((1 << AW) - 1);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    enc_state_e    r_state;
    logic [AW:0]   r_count;
    logic          r_we;
    logic          r_err;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;

    logic [31:0]   w_word;
    logic          w_illegal;

    instr_pack u_pack (
        .i_kind    (in_kind),
        .i_alu     (in_alu),
        .i_rd      (in_rd),
        .i_rs1     (in_rs1),
        .i_rs2     (in_rs2),
        .i_imm     (in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // Load FSM, word counter and the registered memory-write/err outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= {(AW+1){1'b0}};
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= {AW{1'b0}};
            r_wdata <= 32'd0;
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_count <= {(AW+1){1'b0}};
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_we    <= 1'b1;
                            r_addr  <= r_count[AW-1:0];
                            r_wdata <= w_word;
                            r_count <= r_count + ONE;
                        end
                        // A rejected last beat still closes the program.
                        if (in_last || (!w_illegal && (r_count == LAST_IDX))) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == ST_LOAD);
    assign busy       = (r_state == ST_LOAD);
    assign done       = (r_state == ST_DONE);
    assign count      = r_count;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign err        = r_err;

endmodule
